// File: rtl/hmac512_msg_fifo.sv
// rtl/hmac512_msg_fifo.sv - HMAC-512 message FIFO with reg/digest write mux and bit-length accumulator
module hmac512_msg_fifo #(
  parameter int Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       hash_start,
  input  logic                       reg_wvalid,
  input  logic [31:0]                reg_wdata,
  input  logic [3:0]                 reg_wmask,
  output logic                       reg_wready,
  input  logic                       fifo_wsel,
  input  logic                       fifo_wvalid,
  input  logic [2:0]                 fifo_wdata_sel,
  output logic                       fifo_wready,
  input  logic [255:0]               digest,
  output logic                       fifo_rvalid,
  output logic [35:0]                fifo_rdata,
  input  logic                       fifo_rready,
  output logic [$clog2(Depth+1)-1:0] fifo_depth,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [127:0]               message_length
);

  localparam int AW   = $clog2(Depth);
  localparam int PtrW = AW + 1;
  localparam int DW   = $clog2(Depth+1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } sha_fifo_t;

  sha_fifo_t         mem [Depth];
  logic [PtrW-1:0]   wptr, rptr;
  logic [PtrW-1:0]   ptr_diff;
  logic              push, pop;
  sha_fifo_t         wentry;
  logic [31:0]       digest_word;
  logic [2:0]        ones;
  logic [5:0]        len_inc;

  assign ptr_diff   = wptr - rptr;
  assign fifo_depth = DW'(ptr_diff);
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign reg_wready  = !fifo_wsel && !fifo_full && !hash_start;
  assign fifo_wready =  fifo_wsel && !fifo_full && !hash_start;
  assign push = fifo_wsel ? (fifo_wvalid && fifo_wready) : (reg_wvalid && reg_wready);

  // Word 0 is the most significant 32 bits; ~sel == 7 - sel for a 3-bit index.
  assign digest_word = digest[{~fifo_wdata_sel, 5'd0} +: 32];

  always_comb begin
    wentry = '0;
    if (fifo_wsel) begin
      wentry.data = digest_word;
      wentry.mask = 4'hF;
    end else begin
      wentry.data = reg_wdata;
      wentry.mask = reg_wmask;
    end
  end

  assign fifo_rvalid = !fifo_empty && !hash_start;
  assign fifo_rdata  = fifo_rvalid ? mem[rptr[AW-1:0]] : '0;
  assign pop         = fifo_rvalid && fifo_rready;

  assign ones    = {2'b0, reg_wmask[0]} + {2'b0, reg_wmask[1]}
                 + {2'b0, reg_wmask[2]} + {2'b0, reg_wmask[3]};
  assign len_inc = {ones, 3'b000};

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= wentry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr           <= '0;
      rptr           <= '0;
      message_length <= '0;
    end else if (hash_start) begin
      wptr           <= '0;
      rptr           <= '0;
      message_length <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      // Only bus-sourced words contribute to the message bit length.
      if (push && !fifo_wsel) message_length <= message_length + {122'd0, len_inc};
    end
  end

endmodule

// File: tb/tb_hmac512_msg_fifo.sv
// tb/tb_hmac512_msg_fifo.sv - directed self-checking bench for hmac512_msg_fifo
module tb_hmac512_msg_fifo;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         hash_start;
  logic         reg_wvalid;
  logic [31:0]  reg_wdata;
  logic [3:0]   reg_wmask;
  logic         reg_wready;
  logic         fifo_wsel;
  logic         fifo_wvalid;
  logic [2:0]   fifo_wdata_sel;
  logic         fifo_wready;
  logic [255:0] digest;
  logic         fifo_rvalid;
  logic [35:0]  fifo_rdata;
  logic         fifo_rready;
  logic [4:0]   fifo_depth;
  logic         fifo_full;
  logic         fifo_empty;
  logic [127:0] message_length;

  int n_checks = 0;
  int n_fails  = 0;

  hmac512_msg_fifo #(.Depth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .hash_start(hash_start),
    .reg_wvalid(reg_wvalid), .reg_wdata(reg_wdata), .reg_wmask(reg_wmask),
    .reg_wready(reg_wready), .fifo_wsel(fifo_wsel), .fifo_wvalid(fifo_wvalid),
    .fifo_wdata_sel(fifo_wdata_sel), .fifo_wready(fifo_wready), .digest(digest),
    .fifo_rvalid(fifo_rvalid), .fifo_rdata(fifo_rdata), .fifo_rready(fifo_rready),
    .fifo_depth(fifo_depth), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .message_length(message_length)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_depth"}, 128'(fifo_depth), 128'd0);
    chk({tag, "_empty"}, 128'(fifo_empty), 128'd1);
    chk({tag, "_full"},  128'(fifo_full),  128'd0);
    chk({tag, "_rvalid"}, 128'(fifo_rvalid), 128'd0);
    chk({tag, "_rdata"}, 128'(fifo_rdata), 128'd0);
    chk({tag, "_len"},   message_length, 128'd0);
  endtask

  function automatic logic [31:0] dword(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  initial begin
    rst_ni = 1'b0; hash_start = 1'b0; reg_wvalid = 1'b0; reg_wdata = '0; reg_wmask = '0;
    fifo_wsel = 1'b0; fifo_wvalid = 1'b0; fifo_wdata_sel = '0; fifo_rready = 1'b0;
    digest = '0;
    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = dword(i);

    // T1: reset values, three reg writes, ordered pops
    #1;
    chk_reset_vals("t1_rst");
    tick(); tick();
    rst_ni = 1'b1;
    reg_wvalid = 1'b1; reg_wdata = 32'hA000_0001; reg_wmask = 4'hF;
    #1 chk("t1_wready", 128'(reg_wready), 128'd1);
    tick();
    reg_wdata = 32'hA000_0002; reg_wmask = 4'hF; tick();
    reg_wdata = 32'hA000_0003; reg_wmask = 4'h3; tick();
    reg_wvalid = 1'b0;
    #1;
    chk("t1_depth", 128'(fifo_depth), 128'd3);
    chk("t1_len", message_length, 128'd80);
    chk("t1_rvalid", 128'(fifo_rvalid), 128'd1);
    chk("t1_head0", 128'(fifo_rdata), 128'h0_A000_0001_F);
    fifo_rready = 1'b1;
    tick();
    chk("t1_head1", 128'(fifo_rdata), 128'h0_A000_0002_F);
    tick();
    chk("t1_head2", 128'(fifo_rdata), 128'h0_A000_0003_3);
    tick();
    fifo_rready = 1'b0;
    #1;
    chk("t1_empty", 128'(fifo_empty), 128'd1);
    chk("t1_rvalid_e", 128'(fifo_rvalid), 128'd0);
    chk("t1_rdata_e", 128'(fifo_rdata), 128'd0);

    // T2: fill to full, then pop+push in one cycle refuses the push
    reg_wvalid = 1'b1; reg_wmask = 4'hF;
    for (int i = 0; i < 16; i++) begin
      reg_wdata = 32'hB000_0000 + 32'(i);
      tick();
    end
    reg_wvalid = 1'b0;
    #1;
    chk("t2_full", 128'(fifo_full), 128'd1);
    chk("t2_depth", 128'(fifo_depth), 128'd16);
    chk("t2_wready", 128'(reg_wready), 128'd0);
    chk("t2_len", message_length, 128'd592);
    reg_wvalid = 1'b1; reg_wdata = 32'h0000_DEAD; fifo_rready = 1'b1;
    #1 chk("t2_wready_pop", 128'(reg_wready), 128'd0);
    tick();
    reg_wvalid = 1'b0; fifo_rready = 1'b0;
    #1;
    chk("t2_depth15", 128'(fifo_depth), 128'd15);
    chk("t2_head", 128'(fifo_rdata), 128'h0_B000_0001_F);
    chk("t2_len_kept", message_length, 128'd592);
    fifo_rready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("t2_last", 128'(fifo_rdata), 128'h0_B000_000F_F);
    tick();
    fifo_rready = 1'b0;
    #1 chk("t2_empty", 128'(fifo_empty), 128'd1);

    // T3: digest pushes with a stalled concurrent reg write
    fifo_wsel = 1'b1; reg_wvalid = 1'b1; reg_wdata = 32'h0000_CAFE;
    fifo_wvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fifo_wdata_sel = 3'(i);
      #1;
      chk("t3_fwready", 128'(fifo_wready), 128'd1);
      chk("t3_rwready", 128'(reg_wready), 128'd0);
      tick();
    end
    fifo_wvalid = 1'b0;
    #1;
    chk("t3_depth", 128'(fifo_depth), 128'd8);
    chk("t3_len", message_length, 128'd592);
    fifo_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_word", 128'(fifo_rdata), 128'({dword(i), 4'hF}));
      chk("t3_rwready_pop", 128'(reg_wready), 128'd0);
      tick();
    end
    fifo_rready = 1'b0; reg_wvalid = 1'b0; fifo_wsel = 1'b0;
    #1 chk("t3_empty", 128'(fifo_empty), 128'd1);

    // T4: continuous push+pop across pointer wrap
    reg_wvalid = 1'b1; reg_wmask = 4'hF; reg_wdata = 32'hC000_0000;
    tick();
    fifo_rready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      reg_wdata = 32'hC000_0000 + 32'(i);
      #1;
      chk("t4_head", 128'(fifo_rdata), 128'({32'hC000_0000 + 32'(i-1), 4'hF}));
      chk("t4_depth", 128'(fifo_depth), 128'd1);
      tick();
    end
    reg_wvalid = 1'b0;
    #1 chk("t4_tail", 128'(fifo_rdata), 128'h0_C000_0028_F);
    tick();
    fifo_rready = 1'b0;
    #1;
    chk("t4_empty", 128'(fifo_empty), 128'd1);
    chk("t4_len", message_length, 128'd1904);

    // T5: hash_start flush, including with digest source selected
    hash_start = 1'b1; fifo_wsel = 1'b1; fifo_wvalid = 1'b1;
    #1 chk("t5_fwready_hs", 128'(fifo_wready), 128'd0);
    tick();
    hash_start = 1'b0; fifo_wsel = 1'b0; fifo_wvalid = 1'b0;
    #1 chk("t5_len_clr", message_length, 128'd0);
    reg_wvalid = 1'b1; reg_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      reg_wdata = 32'hD000_0000 + 32'(i);
      tick();
    end
    #1;
    chk("t5_depth5", 128'(fifo_depth), 128'd5);
    chk("t5_len160", message_length, 128'd160);
    hash_start = 1'b1; fifo_rready = 1'b1;
    #1;
    chk("t5_rvalid_hs", 128'(fifo_rvalid), 128'd0);
    chk("t5_rdata_hs", 128'(fifo_rdata), 128'd0);
    chk("t5_wready_hs", 128'(reg_wready), 128'd0);
    tick();
    hash_start = 1'b0; reg_wvalid = 1'b0; fifo_rready = 1'b0;
    #1;
    chk("t5_empty", 128'(fifo_empty), 128'd1);
    chk("t5_depth0", 128'(fifo_depth), 128'd0);
    chk("t5_len0", message_length, 128'd0);

    // T6: asynchronous reset mid-stream
    reg_wvalid = 1'b1; reg_wmask = 4'h7;
    for (int i = 0; i < 7; i++) begin
      reg_wdata = 32'hE000_0000 + 32'(i);
      tick();
    end
    #1;
    chk("t6_depth7", 128'(fifo_depth), 128'd7);
    chk("t6_len", message_length, 128'd168);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    reg_wvalid = 1'b0;
    tick();
    rst_ni = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
